// File: rtl/reduce_stream_accum_if.sv
// Stream-in / result-out bundle for reduce_stream_accum.
// out_ones exists only when REDUCE_POPCOUNT_EN is defined.
interface reduce_stream_accum_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 16
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic [CNT_W-1:0] out_beats;
  logic             out_overflow;

`ifdef REDUCE_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH * MAX_BEATS + 1);
  logic [ONES_W-1:0] out_ones;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_and, out_or, out_xor, out_beats, out_overflow, out_ones
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_and, out_or, out_xor, out_beats, out_overflow, out_ones
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_and, out_or, out_xor, out_beats, out_overflow
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_and, out_or, out_xor, out_beats, out_overflow
  );
`endif
endinterface

// File: rtl/reduce_stream_accum.sv
// Frame-wise AND/OR/XOR reduction with saturating beat count over a valid/ready stream.
// Optional popcount output enabled by defining REDUCE_POPCOUNT_EN.
module reduce_stream_accum #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 16
) (
  input logic                 clk,
  input logic                 areset_n,
  reduce_stream_accum_if.slave s
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;

  logic             acc_and_q, acc_and_d;
  logic             acc_or_q, acc_or_d;
  logic             acc_xor_q, acc_xor_d;
  logic [CNT_W-1:0] acc_beats_q, acc_beats_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic             out_valid_q, out_valid_d;
  logic             out_and_q, out_and_d;
  logic             out_or_q, out_or_d;
  logic             out_xor_q, out_xor_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_overflow_q, out_overflow_d;

  logic             accept;
  logic             at_max;
  logic             fold_and, fold_or, fold_xor, fold_ovf;
  logic [CNT_W-1:0] fold_beats;

  // A held result blocks input so it can never be overwritten before it is consumed.
  assign s.in_ready = ~out_valid_q | s.out_ready;
  assign accept     = s.in_valid & s.in_ready;
  assign at_max     = (acc_beats_q == MAX_CNT);

  assign fold_and   = acc_and_q & (&s.in_data);
  assign fold_or    = acc_or_q | (|s.in_data);
  assign fold_xor   = acc_xor_q ^ (^s.in_data);
  assign fold_beats = at_max ? acc_beats_q : acc_beats_q + CNT_W'(1);
  assign fold_ovf   = acc_ovf_q | at_max;

  always_comb begin
    state_d        = state_q;
    acc_and_d      = acc_and_q;
    acc_or_d       = acc_or_q;
    acc_xor_d      = acc_xor_q;
    acc_beats_d    = acc_beats_q;
    acc_ovf_d      = acc_ovf_q;
    out_valid_d    = out_valid_q & ~s.out_ready;
    out_and_d      = out_and_q;
    out_or_d       = out_or_q;
    out_xor_d      = out_xor_q;
    out_beats_d    = out_beats_q;
    out_overflow_d = out_overflow_q;
    if (accept) begin
      if (s.in_last) begin
        state_d        = IDLE;
        out_valid_d    = 1'b1;
        out_and_d      = fold_and;
        out_or_d       = fold_or;
        out_xor_d      = fold_xor;
        out_beats_d    = fold_beats;
        out_overflow_d = fold_ovf;
        acc_and_d      = 1'b1;
        acc_or_d       = 1'b0;
        acc_xor_d      = 1'b0;
        acc_beats_d    = '0;
        acc_ovf_d      = 1'b0;
      end else begin
        state_d     = ACTIVE;
        acc_and_d   = fold_and;
        acc_or_d    = fold_or;
        acc_xor_d   = fold_xor;
        acc_beats_d = fold_beats;
        acc_ovf_d   = fold_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q        <= IDLE;
      acc_and_q      <= 1'b1;
      acc_or_q       <= 1'b0;
      acc_xor_q      <= 1'b0;
      acc_beats_q    <= '0;
      acc_ovf_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_and_q      <= 1'b0;
      out_or_q       <= 1'b0;
      out_xor_q      <= 1'b0;
      out_beats_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_and_q      <= acc_and_d;
      acc_or_q       <= acc_or_d;
      acc_xor_q      <= acc_xor_d;
      acc_beats_q    <= acc_beats_d;
      acc_ovf_q      <= acc_ovf_d;
      out_valid_q    <= out_valid_d;
      out_and_q      <= out_and_d;
      out_or_q       <= out_or_d;
      out_xor_q      <= out_xor_d;
      out_beats_q    <= out_beats_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign s.out_valid    = out_valid_q;
  assign s.out_and      = out_and_q;
  assign s.out_or       = out_or_q;
  assign s.out_xor      = out_xor_q;
  assign s.out_beats    = out_beats_q;
  assign s.out_overflow = out_overflow_q;

`ifdef REDUCE_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH * MAX_BEATS + 1);

  logic [ONES_W-1:0] acc_ones_q, acc_ones_d;
  logic [ONES_W-1:0] out_ones_q, out_ones_d;
  logic [ONES_W-1:0] beat_ones;
  logic [ONES_W-1:0] fold_ones;

  always_comb begin
    beat_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      beat_ones = beat_ones + ONES_W'(s.in_data[i]);
    end
  end

  // Beats past the saturation limit are not counted, matching out_beats.
  assign fold_ones = at_max ? acc_ones_q : acc_ones_q + beat_ones;

  always_comb begin
    acc_ones_d = acc_ones_q;
    out_ones_d = out_ones_q;
    if (accept) begin
      if (s.in_last) begin
        out_ones_d = fold_ones;
        acc_ones_d = '0;
      end else begin
        acc_ones_d = fold_ones;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      acc_ones_q <= '0;
      out_ones_q <= '0;
    end else begin
      acc_ones_q <= acc_ones_d;
      out_ones_q <= out_ones_d;
    end
  end

  assign s.out_ones = out_ones_q;
`endif
endmodule

// File: tb/tb_reduce_stream_accum.sv
// Directed and randomized checks of reduce_stream_accum against a frame-level reference model.
`timescale 1ns/1ps
module tb_reduce_stream_accum;
  localparam int W  = 4;
  localparam int MB = 16;
  localparam int NF = 40;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  reduce_stream_accum_if #(.WIDTH(W), .MAX_BEATS(MB)) ifc ();

  reduce_stream_accum #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .s        (ifc)
  );

  typedef struct packed {
    logic a;
    logic o;
    logic x;
    logic ovf;
    int   beats;
    int   ones;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   rcv = 0;
  logic done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame result from total bit counts: AND means every bit set, OR means any, XOR is parity.
  function automatic res_t ref_model(input logic [W-1:0] w[$]);
    res_t r;
    int total = 0;
    int capped = 0;
    for (int i = 0; i < w.size(); i++) begin
      total += $countones(w[i]);
      if (i < MB) capped += $countones(w[i]);
    end
    r.a     = (total == W * w.size());
    r.o     = (total != 0);
    r.x     = total[0];
    r.beats = (w.size() > MB) ? MB : w.size();
    r.ovf   = (w.size() > MB);
    r.ones  = capped;
    return r;
  endfunction

  task automatic chk_result(input string tag, input res_t e);
    chk({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({tag, "_and"},   32'(ifc.out_and), 32'(e.a));
    chk({tag, "_or"},    32'(ifc.out_or), 32'(e.o));
    chk({tag, "_xor"},   32'(ifc.out_xor), 32'(e.x));
    chk({tag, "_beats"}, 32'(ifc.out_beats), 32'(e.beats));
    chk({tag, "_ovf"},   32'(ifc.out_overflow), 32'(e.ovf));
`ifdef REDUCE_POPCOUNT_EN
    chk({tag, "_ones"},  32'(ifc.out_ones), 32'(e.ones));
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int   n = 0;
    logic took = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = l;
    while (!took && n < 1000) begin
      @(negedge clk);
      took = ifc.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) chk("accept_timeout", 32'd0, 32'd1);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w[$], input int gap_max);
    for (int i = 0; i < w.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_beat(w[i], i == w.size() - 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] q[$];
    res_t e;
    int extra;

    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;

    #12;
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_beats", 32'(ifc.out_beats), 32'd0);
    chk("rst_and", 32'(ifc.out_and), 32'd0);
    #11 areset_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(ifc.out_valid), 32'd0);

    // single-beat sweep
    ifc.out_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      q = {};
      q.push_back(W'(d));
      e = ref_model(q);
      send_frame(q, 0);
      chk_result($sformatf("single%0d", d), e);
    end

    // three-beat frame with fixed expectations
    q = {4'hF, 4'hF, 4'h7};
    send_frame(q, 0);
    chk("f3_and", 32'(ifc.out_and), 32'd0);
    chk("f3_or", 32'(ifc.out_or), 32'd1);
    chk("f3_xor", 32'(ifc.out_xor), 32'd1);
    chk("f3_beats", 32'(ifc.out_beats), 32'd3);
    chk("f3_ovf", 32'(ifc.out_overflow), 32'd0);
`ifdef REDUCE_POPCOUNT_EN
    chk("f3_ones", 32'(ifc.out_ones), 32'd11);
`endif
    tick();

    // backpressure: A held, then consumed while B loads in the same edge
    ifc.out_ready = 1'b0;
    send_beat(4'hF, 1'b1);
    chk("bp_a_valid", 32'(ifc.out_valid), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 4'h1;
    ifc.in_last  = 1'b1;
    repeat (3) tick();
    chk("bp_hold_valid", 32'(ifc.out_valid), 32'd1);
    chk("bp_hold_and", 32'(ifc.out_and), 32'd1);
    chk("bp_hold_xor", 32'(ifc.out_xor), 32'd0);
    chk("bp_hold_beats", 32'(ifc.out_beats), 32'd1);
    chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    chk("bp_b_valid", 32'(ifc.out_valid), 32'd1);
    chk("bp_b_and", 32'(ifc.out_and), 32'd0);
    chk("bp_b_or", 32'(ifc.out_or), 32'd1);
    chk("bp_b_xor", 32'(ifc.out_xor), 32'd1);
    ifc.out_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(ifc.out_valid), 32'd0);

    // saturation boundary
    q = {};
    repeat (MB) q.push_back(4'h0);
    send_frame(q, 0);
    chk("max_beats", 32'(ifc.out_beats), 32'(MB));
    chk("max_ovf", 32'(ifc.out_overflow), 32'd0);
    q.push_back(4'h0);
    send_frame(q, 0);
    chk("ovf_beats", 32'(ifc.out_beats), 32'(MB));
    chk("ovf_ovf", 32'(ifc.out_overflow), 32'd1);
    chk("ovf_and", 32'(ifc.out_and), 32'd0);
    chk("ovf_or", 32'(ifc.out_or), 32'd0);
    tick();

    // asynchronous reset while a result is held
    ifc.out_ready = 1'b0;
    send_beat(4'hF, 1'b1);
    chk("ar_held_valid", 32'(ifc.out_valid), 32'd1);
    #3 areset_n = 1'b0;
    #1;
    chk("ar_held_cleared", 32'(ifc.out_valid), 32'd0);
    chk("ar_held_and", 32'(ifc.out_and), 32'd0);
    #2 areset_n = 1'b1;
    tick();

    // asynchronous reset mid-frame discards the partial frame
    ifc.out_ready = 1'b1;
    send_beat(4'h1, 1'b0);
    send_beat(4'h1, 1'b0);
    #3 areset_n = 1'b0;
    #1;
    chk("ar_mid_valid", 32'(ifc.out_valid), 32'd0);
    chk("ar_mid_in_ready", 32'(ifc.in_ready), 32'd1);
    #2 areset_n = 1'b1;
    tick();
    send_beat(4'h0, 1'b1);
    chk("ar_next_xor", 32'(ifc.out_xor), 32'd0);
    chk("ar_next_or", 32'(ifc.out_or), 32'd0);
    chk("ar_next_beats", 32'(ifc.out_beats), 32'd1);
    chk("ar_next_ovf", 32'(ifc.out_overflow), 32'd0);
    tick();

    // randomized frames with random gaps and backpressure
    fork
      begin
        for (int f = 0; f < NF; f++) begin
          logic [W-1:0] rq[$];
          int n;
          n = $urandom_range(1, 20);
          for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) rq.push_back(4'hF);
            else rq.push_back(W'($urandom_range(0, 15)));
          end
          exp_q.push_back(ref_model(rq));
          send_frame(rq, 2);
        end
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          ifc.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        int cyc = 0;
        res_t re;
        while (rcv < NF && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected", 32'd1, 32'd0);
            end else begin
              re = exp_q.pop_front();
              $display("frame %0d: and=%0d or=%0d xor=%0d beats=%0d ovf=%0d", rcv,
                       ifc.out_and, ifc.out_or, ifc.out_xor, ifc.out_beats, ifc.out_overflow);
              chk_result($sformatf("rand%0d", rcv), re);
            end
            rcv++;
          end
        end
        done = 1'b1;
      end
    join

    ifc.out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.out_valid) extra++;
    end
    chk("rand_count", 32'(rcv), 32'(NF));
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_extra", 32'(extra), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
